// File: rtl/interrupt_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel interrupt manager.
package interrupt_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } irq_state_t;

  // Ceiling log2: number of bits needed to count value distinct states.
  function automatic int log2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Holdoff length in clk cycles.
  function automatic int time_interval_cycles(input int interval_ms, input int clk_freq_khz);
    return interval_ms * clk_freq_khz;
  endfunction

  // Width of a counter that must hold 0..max_value inclusive.
  function automatic int counter_width(input int max_value);
    return (log2(max_value + 1) < 1) ? 1 : log2(max_value + 1);
  endfunction

endpackage

// File: rtl/interrupt_channel.sv
// One interrupt channel: pending flag, reported flag and sticky overflow flag.
module interrupt_channel
  import interrupt_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic full_frame,
  input  logic en,
  input  logic evt,
  input  logic clear,
  input  logic issue,
  output logic pending,
  output logic reported,
  output logic overflow
);

  logic gate;

  assign gate = full_frame & en;

  // Pending flag: a new event wins over a same-cycle clear; gating forces it low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= 1'b0;
    end else if (!gate) begin
      pending <= 1'b0;
    end else if (evt) begin
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

  // Overflow flag: an event landing on an already pending channel is remembered until cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (!gate) begin
      overflow <= 1'b0;
    end else if (evt && pending) begin
      overflow <= 1'b1;
    end else if (clear) begin
      overflow <= 1'b0;
    end
  end

  // Reported flag: latched by the issue strobe, dropped with the pending flag or on gating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reported <= 1'b0;
    end else if (!gate || !pending) begin
      reported <= 1'b0;
    end else if (issue) begin
      reported <= 1'b1;
    end
  end

endmodule

// File: rtl/interrupt_multi.sv
// Multi-channel frame interrupt manager: frame gating, interval holdoff, issue FSM and pin driver.
module interrupt_multi
  import interrupt_pkg::*;
#(
  parameter int INT_NUM              = 2,
  parameter int INT_TIME_INTERVAL_MS = 50,
  parameter int CLK_FREQ_KHZ         = 55000,
  parameter int PULSE_CYCLES         = 16,
  parameter int LEVEL_MODE           = 0,
  parameter int INT_ACTIVE_HIGH      = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_fval,
  input  logic               i_acquisition_start,
  input  logic               i_stream_enable,
  input  logic [INT_NUM-1:0] iv_event,
  input  logic [INT_NUM-1:0] iv_interrupt_en,
  input  logic [INT_NUM-1:0] iv_interrupt_clear,
  output logic [INT_NUM-1:0] ov_interrupt_state,
  output logic [INT_NUM-1:0] ov_event_overflow,
  output logic               o_interrupt
);

  localparam int TIME_INTERVAL = time_interval_cycles(INT_TIME_INTERVAL_MS, CLK_FREQ_KHZ);
  localparam int CNT_WIDTH     = counter_width(TIME_INTERVAL);
  localparam int PCNT_WIDTH    = counter_width(PULSE_CYCLES);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = CNT_WIDTH'(TIME_INTERVAL);
  localparam logic [PCNT_WIDTH-1:0] PULSE_LAST = PCNT_WIDTH'(PULSE_CYCLES - 1);

  logic                  run;
  logic [1:0]            fval_sr;
  logic                  fval_rise;
  logic                  fval_fall;
  logic                  arm;
  logic                  full_frame;
  logic [INT_NUM-1:0]    pending;
  logic [INT_NUM-1:0]    reported;
  logic                  has_unreported;
  logic [CNT_WIDTH-1:0]  interval_cnt;
  logic [CNT_WIDTH-1:0]  interval_cnt_next;
  logic                  time_up;
  irq_state_t            state;
  irq_state_t            state_next;
  logic                  start_issue;
  logic                  issue;
  logic [PCNT_WIDTH-1:0] pulse_cnt;
  logic [PCNT_WIDTH-1:0] pulse_cnt_next;
  logic                  pin_next;
  logic                  pin_q;

  assign run            = i_acquisition_start & i_stream_enable;
  assign fval_rise      = fval_sr[0] & ~fval_sr[1];
  assign fval_fall      = ~fval_sr[0] & fval_sr[1];
  assign has_unreported = |(pending & ~reported);

  // Two-stage fval history used for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fval_sr <= 2'b00;
    end else begin
      fval_sr <= {fval_sr[0], i_fval};
    end
  end

  // Frame qualifier: arm on a rising fval while running, qualify on the following fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm        <= 1'b0;
      full_frame <= 1'b0;
    end else if (!run) begin
      arm        <= 1'b0;
      full_frame <= 1'b0;
    end else begin
      if (fval_rise) begin
        arm <= 1'b1;
      end
      if (fval_fall && arm) begin
        full_frame <= 1'b1;
      end
    end
  end

  genvar j;
  for (j = 0; j < INT_NUM; j++) begin : g_chan
    interrupt_channel u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .full_frame (full_frame),
      .en         (iv_interrupt_en[j]),
      .evt        (iv_event[j]),
      .clear      (iv_interrupt_clear[j]),
      .issue      (issue),
      .pending    (pending[j]),
      .reported   (reported[j]),
      .overflow   (ov_event_overflow[j])
    );
  end

  assign ov_interrupt_state = reported;

  // Holdoff counter restarts on the issue decision and saturates at the interval.
  always_comb begin
    interval_cnt_next = interval_cnt;
    if (start_issue) begin
      interval_cnt_next = '0;
    end else if (interval_cnt != CNT_MAX) begin
      interval_cnt_next = interval_cnt + 1'b1;
    end
  end

  // Holdoff register; time_up tracks the counter value of the coming cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval_cnt <= CNT_MAX;
      time_up      <= 1'b0;
    end else begin
      interval_cnt <= interval_cnt_next;
      time_up      <= (interval_cnt_next == CNT_MAX);
    end
  end

  // Issue FSM: leave IDLE once the holdoff expired and an unreported channel waits.
  always_comb begin
    state_next     = state;
    start_issue    = 1'b0;
    pin_next       = 1'b0;
    pulse_cnt_next = pulse_cnt;
    case (state)
      IDLE: begin
        pulse_cnt_next = '0;
        if (time_up && has_unreported) begin
          state_next  = ACTIVE;
          start_issue = 1'b1;
        end
      end
      ACTIVE: begin
        if (LEVEL_MODE != 0) begin
          pin_next = issue | (|reported);
          if (!pin_next) begin
            state_next = IDLE;
          end
        end else begin
          pin_next       = 1'b1;
          pulse_cnt_next = pulse_cnt + 1'b1;
          if (pulse_cnt == PULSE_LAST) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, issue strobe, pulse width counter and pin register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      issue     <= 1'b0;
      pulse_cnt <= '0;
      pin_q     <= 1'b0;
    end else begin
      state     <= state_next;
      issue     <= start_issue;
      pulse_cnt <= pulse_cnt_next;
      pin_q     <= pin_next;
    end
  end

  assign o_interrupt = (INT_ACTIVE_HIGH != 0) ? pin_q : ~pin_q;

endmodule

// File: tb/tb_interrupt_multi.sv
// Bench for interrupt_multi: a pulse/active-high and a level/active-low instance share stimulus.
module tb_interrupt_multi;

  localparam int N  = 4;
  localparam int TI = 100;
  localparam int PW = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_fval = 1'b0;
  logic         acq = 1'b0;
  logic         se = 1'b0;
  logic [N-1:0] ev = '0;
  logic [N-1:0] en = '0;
  logic [N-1:0] clr = '0;

  logic [N-1:0] statePulse, ovfPulse, stateLevel, ovfLevel;
  logic         pinPulse, pinLevel;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;

  // reference model state
  bit           mFv0, mFv1, mArm, mFull;
  logic [N-1:0] mPend [2];
  logic [N-1:0] mRep  [2];
  logic [N-1:0] mOvf  [2];
  bit           mActive [2];
  bit           mPin    [2];
  int           mLastDec [2];
  int           mCyc = 0;

  always #5 clk = ~clk;

  interrupt_multi #(
    .INT_NUM(N), .INT_TIME_INTERVAL_MS(1), .CLK_FREQ_KHZ(100),
    .PULSE_CYCLES(PW), .LEVEL_MODE(0), .INT_ACTIVE_HIGH(1)
  ) dutPulse (
    .clk(clk), .reset_n(reset_n), .i_fval(i_fval),
    .i_acquisition_start(acq), .i_stream_enable(se),
    .iv_event(ev), .iv_interrupt_en(en), .iv_interrupt_clear(clr),
    .ov_interrupt_state(statePulse), .ov_event_overflow(ovfPulse),
    .o_interrupt(pinPulse)
  );

  interrupt_multi #(
    .INT_NUM(N), .INT_TIME_INTERVAL_MS(1), .CLK_FREQ_KHZ(100),
    .PULSE_CYCLES(PW), .LEVEL_MODE(1), .INT_ACTIVE_HIGH(0)
  ) dutLevel (
    .clk(clk), .reset_n(reset_n), .i_fval(i_fval),
    .i_acquisition_start(acq), .i_stream_enable(se),
    .iv_event(ev), .iv_interrupt_en(en), .iv_interrupt_clear(clr),
    .ov_interrupt_state(stateLevel), .ov_event_overflow(ovfLevel),
    .o_interrupt(pinLevel)
  );

  // Behavioural model: channel flags from the gating rules, issues from cycle-number spacing.
  always @(posedge clk) begin : refModel
    bit           runNow, riseSeen, fallSeen, issueNow, decide, anyRep;
    logic [N-1:0] gateVec, nPend, nOvf, nRep;
    if (!reset_n) begin
      mFv0 = 0; mFv1 = 0; mArm = 0; mFull = 0;
      for (int k = 0; k < 2; k++) begin
        mPend[k] = '0; mRep[k] = '0; mOvf[k] = '0;
        mActive[k] = 0; mPin[k] = 0; mLastDec[k] = mCyc - 200;
      end
    end else begin
      gateVec = mFull ? en : '0;
      for (int k = 0; k < 2; k++) begin
        issueNow = mActive[k] && (mCyc == mLastDec[k] + 1);
        anyRep   = |mRep[k];
        decide   = !mActive[k] && (mCyc - mLastDec[k] >= TI + 1) && (|(mPend[k] & ~mRep[k]));
        nPend    = gateVec & (ev | (mPend[k] & ~clr));
        nOvf     = gateVec & ((ev & mPend[k]) | (mOvf[k] & ~clr));
        nRep     = gateVec & mPend[k] & (mRep[k] | {N{issueNow}});
        if (mActive[k]) begin
          if (k == 0) begin
            mPin[k]    = (mCyc <= mLastDec[k] + PW);
            mActive[k] = (mCyc < mLastDec[k] + PW);
          end else begin
            mPin[k]    = issueNow || anyRep;
            mActive[k] = mPin[k];
          end
        end else begin
          mPin[k]    = 0;
          mActive[k] = decide;
          if (decide) mLastDec[k] = mCyc;
        end
        mPend[k] = nPend;
        mOvf[k]  = nOvf;
        mRep[k]  = nRep;
      end
      runNow   = acq & se;
      riseSeen = mFv0 & !mFv1;
      fallSeen = !mFv0 & mFv1;
      mFull    = runNow && (mFull || (fallSeen && mArm));
      mArm     = runNow && (mArm || riseSeen);
      mFv1     = mFv0;
      mFv0     = i_fval;
    end
    mCyc++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycleNum);
    end
  endtask

  task automatic compareModel();
    logic expLevelPin;
    expLevelPin = !mPin[1];
    checkOutput("model pulse pin",   pinPulse,   mPin[0]);
    checkOutput("model pulse state", statePulse, mRep[0]);
    checkOutput("model pulse ovf",   ovfPulse,   mOvf[0]);
    checkOutput("model level pin",   pinLevel,   expLevelPin);
    checkOutput("model level state", stateLevel, mRep[1]);
    checkOutput("model level ovf",   ovfLevel,   mOvf[1]);
  endtask

  task automatic applyStimulus(input logic [N-1:0] evs, input logic [N-1:0] clrs);
    ev  = evs;
    clr = clrs;
    @(negedge clk);
    cycleNum++;
    ev  = '0;
    clr = '0;
    compareModel();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, '0);
  endtask

  task automatic frame(input int len);
    i_fval = 1'b1;
    idle(len);
    i_fval = 1'b0;
    idle(4);
  endtask

  task automatic waitRise(input int limit);
    int w;
    w = 0;
    while (!pinPulse && w < limit) begin
      idle(1);
      w++;
    end
    checkOutput("pulse rise within bound", pinPulse, 1'b1);
  endtask

  task automatic waitFall(input int limit);
    int w;
    w = 0;
    while (pinPulse && w < limit) begin
      idle(1);
      w++;
    end
    checkOutput("pulse fall within bound", pinPulse, 1'b0);
  endtask

  initial begin
    int riseCycle, prevRise;
    logic [N-1:0] rEv, rClr;
    en = 4'hF;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    checkOutput("reset state", statePulse, 4'b0000);
    checkOutput("reset pulse pin", pinPulse, 1'b0);
    checkOutput("reset level pin", pinLevel, 1'b1);

    // 1: partial frame discarded, then first full frame and event latency
    i_fval = 1'b1;
    idle(3);
    acq = 1'b1;
    se  = 1'b1;
    idle(5);
    i_fval = 1'b0;
    idle(4);
    applyStimulus(4'b0001, 4'b0000);
    idle(6);
    checkOutput("partial frame pin", pinPulse, 1'b0);
    checkOutput("partial frame state", statePulse, 4'b0000);
    frame(10);
    applyStimulus(4'b0001, 4'b0000);
    idle(1);
    checkOutput("latency t+2 pin", pinPulse, 1'b0);
    idle(1);
    checkOutput("latency t+3 pin", pinPulse, 1'b1);
    checkOutput("first issue state", statePulse, 4'b0001);
    riseCycle = cycleNum;
    waitFall(40);
    checkOutput("pulse width", cycleNum - riseCycle, PW);

    // 2: event inside the holdoff issues exactly at interval expiry
    idle(2);
    applyStimulus(4'b0010, 4'b0000);
    waitRise(150);
    prevRise  = riseCycle;
    riseCycle = cycleNum;
    checkOutput("issue spacing", riseCycle - prevRise, TI + 1);
    checkOutput("second issue state", statePulse, 4'b0011);
    waitFall(40);
    checkOutput("second pulse width", cycleNum - riseCycle, PW);

    // 3: overflow set, set-wins-over-clear, lone clear
    applyStimulus(4'b0100, 4'b0000);
    idle(2);
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("ovf double event", ovfPulse, 4'b0100);
    applyStimulus(4'b0100, 4'b0100);
    checkOutput("ovf set wins", ovfPulse, 4'b0100);
    applyStimulus(4'b0000, 4'b0100);
    checkOutput("ovf lone clear", ovfPulse, 4'b0000);

    // 4: level mode, active low pin follows the reported channel
    applyStimulus(4'b0000, 4'b1111);
    idle(130);
    checkOutput("level idle pin", pinLevel, 1'b1);
    applyStimulus(4'b1000, 4'b0000);
    idle(2);
    checkOutput("level pin active", pinLevel, 1'b0);
    checkOutput("level state", stateLevel, 4'b1000);
    idle(5);
    checkOutput("level pin held", pinLevel, 1'b0);
    applyStimulus(4'b0000, 4'b1000);
    idle(1);
    checkOutput("level pin c+2", pinLevel, 1'b0);
    idle(1);
    checkOutput("level pin c+3", pinLevel, 1'b1);

    // 5: stream disabled during a pulse
    idle(110);
    applyStimulus(4'b0001, 4'b0000);
    idle(2);
    checkOutput("stop test rise", pinPulse, 1'b1);
    riseCycle = cycleNum;
    applyStimulus(4'b0010, 4'b0000);
    applyStimulus(4'b0010, 4'b0000);
    checkOutput("stop test ovf before", ovfPulse, 4'b0010);
    idle(2);
    se = 1'b0;
    idle(2);
    checkOutput("stop state cleared", statePulse, 4'b0000);
    checkOutput("stop ovf cleared", ovfPulse, 4'b0000);
    waitFall(40);
    checkOutput("stop pulse width", cycleNum - riseCycle, PW);
    se = 1'b1;
    applyStimulus(4'b0001, 4'b0000);
    idle(10);
    checkOutput("no issue without frame", pinPulse, 1'b0);
    checkOutput("no state without frame", statePulse, 4'b0000);

    // 6: async reset mid-pulse, then no holdoff after release
    frame(10);
    idle(110);
    applyStimulus(4'b0001, 4'b0000);
    idle(2);
    checkOutput("pre-reset rise", pinPulse, 1'b1);
    idle(4);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset pulse pin", pinPulse, 1'b0);
    checkOutput("async reset level pin", pinLevel, 1'b1);
    checkOutput("async reset state", statePulse, 4'b0000);
    idle(3);
    reset_n = 1'b1;
    frame(10);
    applyStimulus(4'b0001, 4'b0000);
    idle(1);
    checkOutput("post-reset t+2", pinPulse, 1'b0);
    idle(1);
    checkOutput("post-reset no holdoff", pinPulse, 1'b1);

    // Random traffic with periodic frames
    for (int i = 0; i < 2500; i++) begin
      i_fval = ((i % 50) < 30);
      se     = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 99) == 0) en = 4'($urandom);
      for (int b = 0; b < N; b++) begin
        rEv[b]  = ($urandom_range(0, 15) == 0);
        rClr[b] = ($urandom_range(0, 23) == 0);
      end
      applyStimulus(rEv, rClr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
